// File: rtl/reset_sequencer_if.sv
// Signal bundle between the reset sequencer and its surroundings.
// Handshake semantics: there is no valid/ready pair. sw_reset_req is a
// one-cycle strobe sampled on every rising tx_clk edge; pll_locked is an
// asynchronous level; all outputs are registered levels valid every cycle.
`timescale 1ns/1ps
interface reset_sequencer_if #(
    parameter int NUM_STAGES = 4
);
    logic                  pll_locked;
    logic                  sw_reset_req;
    logic                  phy_reset_n;
    logic [NUM_STAGES-1:0] stage_reset_n;
    logic                  seq_done;
    logic                  busy;
    logic [3:0]            retry_count;

    // Side that drives the requests and observes the resets
    modport master (
        output pll_locked,
        output sw_reset_req,
        input  phy_reset_n,
        input  stage_reset_n,
        input  seq_done,
        input  busy,
        input  retry_count
    );

    // The sequencer itself
    modport slave (
        input  pll_locked,
        input  sw_reset_req,
        output phy_reset_n,
        output stage_reset_n,
        output seq_done,
        output busy,
        output retry_count
    );
endinterface

// File: rtl/reset_sequencer.sv
// Staged reset controller: holds the PHY in reset, waits for a filtered PLL
// lock, then releases NUM_STAGES downstream reset domains one gap apart.
// A software request or a lock loss after acceptance restarts the sequence.
`timescale 1ns/1ps
module reset_sequencer #(
    parameter int NUM_STAGES     = 4,
    parameter int CNT_W          = 24,
    parameter int HOLD_CYCLES    = 1000000,
    parameter int LOCK_FILTER    = 256,
    parameter int TIMEOUT_CYCLES = 4000000,
    parameter int GAP_CYCLES     = 64
) (
    input  logic                    tx_clk,
    input  logic                    reset_n_in,
    reset_sequencer_if.slave        bus,
    output logic [1:0]              o_dbg_state
);

    localparam int KW = $clog2(NUM_STAGES + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLT_LAST  = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [KW-1:0]    K_LAST    = KW'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        S_HOLD      = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_RELEASE   = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0]      r_flt, w_flt_nxt;
    logic [KW-1:0]         r_k, w_k_nxt;
    logic                  r_phy, w_phy_nxt;
    logic [NUM_STAGES-1:0] r_stage, w_stage_nxt;
    logic                  r_done, w_done_nxt;
    logic                  r_busy, w_busy_nxt;
    logic [3:0]            r_retry, w_retry_nxt;
    logic [1:0]            r_sync;
    logic                  w_lock_s;
    logic                  w_abort;

    assign w_lock_s = r_sync[1];

    // Lock loss only matters once lock has been accepted
    assign w_abort = bus.sw_reset_req ||
                     (!w_lock_s && (r_state == S_RELEASE || r_state == S_RUN));

    // Two-flop synchronizer bringing pll_locked into the tx_clk domain
    always_ff @(posedge tx_clk or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], bus.pll_locked};
        end
    end

    // State and datapath registers
    always_ff @(posedge tx_clk or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state <= S_HOLD;
            r_cnt   <= '0;
            r_flt   <= '0;
            r_k     <= '0;
            r_phy   <= 1'b0;
            r_stage <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_retry <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_flt   <= w_flt_nxt;
            r_k     <= w_k_nxt;
            r_phy   <= w_phy_nxt;
            r_stage <= w_stage_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= w_busy_nxt;
            r_retry <= w_retry_nxt;
        end
    end

    // Next-state and next-output logic; aborts override every state
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_flt_nxt   = r_flt;
        w_k_nxt     = r_k;
        w_phy_nxt   = r_phy;
        w_stage_nxt = r_stage;
        w_done_nxt  = r_done;
        w_busy_nxt  = r_busy;
        w_retry_nxt = r_retry;

        if (w_abort) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = '0;
            w_flt_nxt   = '0;
            w_k_nxt     = '0;
            w_phy_nxt   = 1'b0;
            w_stage_nxt = '0;
            w_done_nxt  = 1'b0;
            w_busy_nxt  = 1'b1;
        end else begin
            case (r_state)
                S_HOLD: begin
                    w_phy_nxt   = 1'b0;
                    w_stage_nxt = '0;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    if (r_cnt == HOLD_LAST) begin
                        w_cnt_nxt   = '0;
                        w_flt_nxt   = '0;
                        w_phy_nxt   = 1'b1;
                        w_state_nxt = S_WAIT_LOCK;
                    end
                end
                S_WAIT_LOCK: begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    w_flt_nxt = w_lock_s ? (r_flt + CNT_W'(1)) : '0;
                    // Lock acceptance takes precedence over the timeout
                    if (w_lock_s && r_flt == FLT_LAST) begin
                        w_cnt_nxt   = '0;
                        w_k_nxt     = '0;
                        w_state_nxt = S_RELEASE;
                    end else if (r_cnt == TO_LAST) begin
                        w_cnt_nxt   = '0;
                        w_phy_nxt   = 1'b0;
                        w_state_nxt = S_HOLD;
                        if (r_retry != 4'd15) begin
                            w_retry_nxt = r_retry + 4'd1;
                        end
                    end
                end
                S_RELEASE: begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == GAP_LAST) begin
                        w_cnt_nxt = '0;
                        w_k_nxt   = r_k + KW'(1);
                        for (int i = 0; i < NUM_STAGES; i++) begin
                            if (KW'(i) == r_k) begin
                                w_stage_nxt[i] = 1'b1;
                            end
                        end
                        if (r_k == K_LAST) begin
                            w_state_nxt = S_RUN;
                            w_done_nxt  = 1'b1;
                            w_busy_nxt  = 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    w_state_nxt = S_RUN;
                end
                default: begin
                    w_state_nxt = S_HOLD;
                end
            endcase
        end
    end

    assign bus.phy_reset_n   = r_phy;
    assign bus.stage_reset_n = r_stage;
    assign bus.seq_done      = r_done;
    assign bus.busy          = r_busy;
    assign bus.retry_count   = r_retry;
    assign o_dbg_state       = r_state;

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Staged reset controller for the tx_clk domain. After board reset it holds the Ethernet PHY in reset for a fixed time, then waits for a debounced PLL lock. It then releases NUM_STAGES downstream reset domains one at a time, a fixed gap apart. A software request, or loss of lock after lock was accepted, re-runs the full sequence without toggling the board reset.

## Interface
- NUM_STAGES, 4: number of sequenced downstream reset outputs; range 1..16.
- CNT_W, 24: width of the shared cycle counter.
- HOLD_CYCLES, 1000000: cycles phy_reset_n is held low; range 1..2^CNT_W-1.
- LOCK_FILTER, 256: consecutive synchronized-high pll_locked samples needed to accept lock; range 1..2^CNT_W-1.
- TIMEOUT_CYCLES, 4000000: maximum WAIT_LOCK duration before retry; must exceed LOCK_FILTER.
- GAP_CYCLES, 64: cycles between successive stage releases; range 1..2^CNT_W-1.
- tx_clk  in  1  system clock; all logic is on the rising edge.
- reset_n_in  in  1  asynchronous, active-low reset.
- pll_locked  in  1  PLL lock, asynchronous to tx_clk; passed through a 2-flop synchronizer (lock_s).
- sw_reset_req  in  1  single-cycle synchronous request to restart the sequence.
- phy_reset_n  out  1  PHY reset, active-low, registered.
- stage_reset_n  out  NUM_STAGES  downstream resets, active-low, registered; bit 0 is released first.
- seq_done  out  1  high in RUN only.
- busy  out  1  high in every state except RUN.
- retry_count  out  4  saturating count of lock timeouts since reset_n_in.

## Operation
- States: HOLD, WAIT_LOCK, RELEASE, RUN. One shared counter cnt (CNT_W bits); filter counter flt (CNT_W bits); stage index k (ceil(log2(NUM_STAGES+1)) bits).
- Reset values (reset_n_in low):
  - state=HOLD; cnt, flt, k=0; both synchronizer flops=0.
  - phy_reset_n=0; stage_reset_n=all 0; seq_done=0; busy=1; retry_count=0.
- HOLD:
  - phy_reset_n=0 and all stages=0; cnt increments each cycle.
  - When cnt==HOLD_CYCLES-1: cnt<=0, flt<=0, phy_reset_n<=1, go to WAIT_LOCK.
- WAIT_LOCK:
  - cnt increments each cycle.
  - flt increments while lock_s=1 and clears when lock_s=0.
  - When lock_s=1 and flt==LOCK_FILTER-1: go to RELEASE with cnt<=0, k<=0.
  - Otherwise, when cnt==TIMEOUT_CYCLES-1: go to HOLD with cnt<=0, phy_reset_n<=0, retry_count<=retry_count+1, saturating at 15.
  - If both conditions are true in the same cycle, lock acceptance wins.
- RELEASE:
  - cnt increments each cycle.
  - When cnt==GAP_CYCLES-1: stage_reset_n[k]<=1, k<=k+1, cnt<=0.
  - On the release of stage NUM_STAGES-1, go to RUN and set seq_done<=1, busy<=0 on the same edge.
  - Stages already released stay high; stages not yet released stay low.
- RUN: holds until one of the abort conditions below.
- Abort conditions, checked in every state, with priority sw_reset_req > lock loss > normal transition:
  - sw_reset_req=1 in any state (including HOLD) forces HOLD on the next edge.
  - lock_s=0 in RELEASE or RUN forces HOLD on the next edge.
  - On abort: cnt<=0, flt<=0, k<=0, phy_reset_n<=0, all stages<=0, seq_done<=0, busy<=1.
  - retry_count is not changed by an abort.
- lock_s dropping in WAIT_LOCK only clears flt; it is not an abort.
- reset_n_in assertion mid-sequence returns every register to its reset value immediately (asynchronous).
- Counter comparisons use equality only. Parameters must fit in CNT_W, so cnt never wraps.

## Timing
- Edge 1 is the first rising edge with reset_n_in high. Assume pll_locked is steady high, so lock_s is high by edge 2.
- phy_reset_n rises after edge HOLD_CYCLES; WAIT_LOCK then occupies edges HOLD_CYCLES+1 onward.
- RELEASE is entered after edge HOLD_CYCLES+LOCK_FILTER when lock_s is already stable.
- Stage j rises after edge HOLD_CYCLES+LOCK_FILTER+(j+1)*GAP_CYCLES.
- seq_done rises on the same edge as the last stage.
- Abort latency: the cycle after the request or lock-loss sample, all outputs are low (phy_reset_n, stages, seq_done).
- pll_locked to lock_s latency is 2 edges.

## Test plan
Parameters for all scenarios: HOLD_CYCLES=8, LOCK_FILTER=4, TIMEOUT_CYCLES=32, GAP_CYCLES=3, NUM_STAGES=4.
- Nominal, pll_locked=1 from reset: phy_reset_n rises after edge 8; stages 0..3 rise after edges 15, 18, 21, 24; seq_done=1 and busy=0 after edge 24.
- Lock glitch during filtering: drop pll_locked for 1 cycle mid-WAIT_LOCK -> flt restarts; RELEASE is delayed by exactly the glitch position plus 4 clean samples; retry_count stays 0.
- pll_locked=0 for the first 45 cycles: first timeout -> retry_count=1, phy_reset_n back low for 8 cycles; the sequence then completes normally on the retry. Hold pll_locked low permanently: retry_count saturates at 15 and never wraps.
- sw_reset_req pulse in RUN and in RELEASE with stages 0..1 released: next cycle all outputs low, busy=1; full sequence repeats with the nominal spacing.
- Lock loss in RUN (pll_locked low 1 cycle): HOLD is entered 3 edges after pll_locked falls; sw_reset_req and lock loss in the same cycle give an identical single abort.
- Assert reset_n_in mid-RELEASE: outputs drop asynchronously with no clock; retry_count=0 after release.
